// File: rtl/prog_mem_pkg.sv
// rtl/prog_mem_pkg.sv - shared widths and FSM encoding for the program-memory responder
package prog_mem_pkg;

    localparam int WORD_W = 6;
    localparam int ADDR_W = 6;

    typedef enum logic [2:0] {
        LEN  = 3'd0,
        DATA = 3'd1,
        CHK  = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } state_e;

endpackage

// File: rtl/prog_mem_if.sv
// rtl/prog_mem_if.sv - TinyTapeout-style pin frame between CPU tile and program memory
interface prog_mem_if;

    // io_in[1:0] carry clk/reset and are wired as plain ports on the responder
    logic [7:2] io_in;
    logic [7:0] io_out;

    modport master (
        output io_in,
        input  io_out
    );

    modport slave (
        input  io_in,
        output io_out
    );

endinterface

// File: rtl/prog_mem_array.sv
// rtl/prog_mem_array.sv - DEPTH x WORD_W flop array, sync write/clear, combinational read
module prog_mem_array
    import prog_mem_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];

    logic raddr_ok;
    logic waddr_ok;

    assign raddr_ok = {1'b0, raddr} < DEPTH_V;
    assign waddr_ok = {1'b0, waddr} < DEPTH_V;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr_ok) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (raddr_ok) begin
            rdata = mem[raddr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/prog_mem_responder.sv
// rtl/prog_mem_responder.sv - loads a serial program image, then serves zero-latency reads
module prog_mem_responder
    import prog_mem_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    prog_mem_if.slave  bus
);

    localparam logic [2:0] S_LEN  = LEN;
    localparam logic [2:0] S_DATA = DATA;
    localparam logic [2:0] S_CHK  = CHK;
    localparam logic [2:0] S_RUN  = RUN;
    localparam logic [2:0] S_ERR  = ERR;

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [2:0]        state;
    logic [WORD_W-1:0] n_len;
    logic [ADDR_W-1:0] cnt;
    logic [WORD_W-1:0] chk;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] rdata;
    logic              we;

    assign word = bus.io_in[7:2];

    // Words past DEPTH are still counted and checksummed, just not stored
    assign we = (state == S_DATA) && ({1'b0, cnt} < DEPTH_V);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LEN;
            n_len <= '0;
            cnt   <= '0;
            chk   <= '0;
        end else begin
            case (state)
                S_LEN: begin
                    n_len <= word;
                    chk   <= word;
                    cnt   <= '0;
                    state <= (word == '0) ? S_CHK : S_DATA;
                end
                S_DATA: begin
                    chk <= chk ^ word;
                    cnt <= cnt + 1'b1;
                    if (cnt == n_len - 1'b1) begin
                        state <= S_CHK;
                    end
                end
                S_CHK: begin
                    state <= (word == chk) ? S_RUN : S_ERR;
                end
                S_RUN, S_ERR: begin
                    state <= state;
                end
                default: begin
                    state <= S_LEN;
                end
            endcase
        end
    end

    prog_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .clr   (reset),
        .we    (we),
        .waddr (cnt),
        .wdata (word),
        .raddr (word),
        .rdata (rdata)
    );

    // Flags come straight from the state register so they never glitch
    always_comb begin
        bus.io_out = 8'h00;
        case (state)
            S_RUN:   bus.io_out = {1'b0, 1'b1, rdata};
            S_ERR:   bus.io_out = 8'h80;
            default: bus.io_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_prog_mem_responder.sv
// tb/tb_prog_mem_responder.sv - self-checking bench for prog_mem_responder
module tb_prog_mem_responder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [7:0] sb_q[$];

    typedef struct {
        logic [5:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t good_tab[5];

    prog_mem_if bus ();

    prog_mem_responder #(
        .DEPTH (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic feed(input logic [5:0] w);
        bus.io_in = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int edges);
        reset = 1'b1;
        repeat (edges) begin
            bus.io_in = 6'($urandom);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic read_addr(input string name, input logic [5:0] a, input logic [7:0] exp);
        logic [7:0] want;
        sb_q.push_back(exp);
        bus.io_in = a;
        #2;
        want = sb_q.pop_front();
        check(name, bus.io_out, want);
    endtask

    initial begin
        logic [5:0] c;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        bus.io_in = 6'($urandom);

        // Reset behaviour
        reset = 1'b1;
        repeat (2) begin
            bus.io_in = 6'($urandom);
            @(posedge clk);
            #1;
            check("reset_hold", bus.io_out, 8'h00);
        end
        reset = 1'b0;
        bus.io_in = 6'h3f;
        #1;
        check("reset_release_len", bus.io_out, 8'h00);

        // Good load, then table-driven reads
        do_reset(1);
        feed(6'd3);
        feed(6'd1);
        feed(6'd2);
        feed(6'd3);
        check("good_chk_state_quiet", bus.io_out, 8'h00);
        feed(6'd3);
        check("good_run_flag", {7'd0, bus.io_out[6]}, 8'h01);

        good_tab[0] = '{addr: 6'd0,  exp: 8'h41};
        good_tab[1] = '{addr: 6'd1,  exp: 8'h42};
        good_tab[2] = '{addr: 6'd2,  exp: 8'h43};
        good_tab[3] = '{addr: 6'd3,  exp: 8'h40};
        good_tab[4] = '{addr: 6'd40, exp: 8'h40};
        for (int i = 0; i < 5; i++) begin
            read_addr($sformatf("good_read_a%0d", good_tab[i].addr), good_tab[i].addr, good_tab[i].exp);
        end
        repeat (3) feed(6'($urandom));
        read_addr("good_sticky_a0", 6'd0, 8'h41);

        // Bad checksum
        do_reset(1);
        feed(6'd3);
        feed(6'd1);
        feed(6'd2);
        feed(6'd3);
        feed(6'd5);
        check("bad_err", bus.io_out, 8'h80);
        for (int i = 0; i < 10; i++) begin
            feed(6'($urandom));
            check($sformatf("bad_sticky_%0d", i), bus.io_out, 8'h80);
        end

        // Empty image
        do_reset(1);
        feed(6'd0);
        check("empty_in_chk", bus.io_out, 8'h00);
        feed(6'd0);
        check("empty_run_flag", {7'd0, bus.io_out[6]}, 8'h01);
        for (int a = 0; a < 64; a++) begin
            read_addr($sformatf("empty_read_a%0d", a), 6'(a), 8'h40);
        end

        // Overlong image: 20 words into a 16-deep array
        do_reset(1);
        c = 6'd20;
        feed(6'd20);
        for (int i = 1; i <= 20; i++) begin
            feed(6'(i));
            c = c ^ 6'(i);
        end
        check("long_before_chk", bus.io_out, 8'h00);
        feed(c);
        check("long_run_flag", {7'd0, bus.io_out[6]}, 8'h01);
        read_addr("long_read_a0", 6'd0, 8'h41);
        read_addr("long_read_a15", 6'd15, 8'h50);
        for (int a = 16; a < 20; a++) begin
            read_addr($sformatf("long_read_a%0d", a), 6'(a), 8'h40);
        end

        // Reset in the middle of DATA clears the partial image
        do_reset(1);
        feed(6'd2);
        feed(6'd7);
        do_reset(1);
        check("mid_reset_out", bus.io_out, 8'h00);
        feed(6'd1);
        feed(6'd9);
        feed(6'd8);
        check("mid_run_flag", {7'd0, bus.io_out[6]}, 8'h01);
        read_addr("mid_read_a0", 6'd0, 8'h49);
        read_addr("mid_read_a1", 6'd1, 8'h40);

        // Reset has priority in RUN as well
        reset = 1'b1;
        bus.io_in = 6'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("run_reset_clears", bus.io_out, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_mem_responder.md
# prog_mem_responder

Program-memory responder for the 6-bit accumulator CPU tile: it answers the CPU's 6-bit address requests with 6-bit instruction/data words. After reset it first accepts a serial program image (length word, data words, XOR checksum) on the same 6-bit bus, then switches to serving reads. It sits on the other end of the CPU's `mem_request` → `mem_in` path and uses the same fixed TinyTapeout 8-in/8-out pin frame.

## Interface
- `DEPTH`, default 16 — number of stored 6-bit words, legal range 1..64.
- `io_in[0]` (`clk`), input, width 1 — the single clock; all state changes on its rising edge.
- `io_in[1]` (`reset`), input, width 1 — synchronous, active-high reset.
- `io_in[7:2]`, input, width 6 — in load phase, the image word consumed this cycle; in run phase, the read address.
- `io_out[5:0]`, output, width 6 — read data.
- `io_out[6]`, output, width 1 — `run`: image accepted, reads are valid.
- `io_out[7]`, output, width 1 — `err`: checksum mismatch.

## Operation
- **Reset** (sampled at a clock edge):
  - state ← `LEN`.
  - All `DEPTH` memory words, the word counter, length register and checksum accumulator ← 0.
  - Outputs are all 0 during reset and in every state except `RUN`/`ERR`.
- **FSM** advances one state per consumed word. Each non-reset clock edge consumes exactly one word from `io_in[7:2]`; there are no idle cycles.
  - `LEN`: latch N = word; chk ← word; cnt ← 0. Next state is `CHK` if N == 0, else `DATA`.
  - `DATA`:
    - If cnt < DEPTH, mem[cnt] ← word; words at cnt ≥ DEPTH are discarded but still consumed and checksummed.
    - chk ← chk ^ word; cnt ← cnt + 1.
    - Move to `CHK` when cnt == N−1 at this edge.
  - `CHK`: next state is `RUN` if word == chk, else `ERR`.
  - `RUN`, `ERR`: sticky until reset; further input does not change memory.
- **Read path** (`RUN` only):
  - `io_out[5:0]` is combinational from the stored flops: mem[addr] when addr < DEPTH, else 0.
  - There is no read register.
- **`ERR`**: `io_out` = 8'b1000_0000; the data field is forced to 0.
- **`run`/`err` flags** are decoded directly from the state register, so they are registered and glitch-free.
- **Width rules**:
  - N is 6 bits (0..63).
  - cnt is 6 bits and never wraps, because it stops at N ≤ 63.
  - chk is a 6-bit XOR over the length word and all N data words.

## Timing
- Image load takes N+2 edges after reset deasserts.
- `run` (or `err`) rises after the edge that consumes the checksum word.
- **Read latency is zero cycles.** The CPU drives an address after edge k and samples data at edge k+1, so the data must be valid within the same cycle as the address.
- **Reset mid-load** (any state): the next edge returns to `LEN` with memory cleared. No partial image survives.
- A checksum word equal to chk while in `DATA` has no special meaning; only `CHK` compares.
- `reset` has priority over every state transition and memory write at the same edge.

## Structure
- **Package `prog_mem_pkg`**:
  - `WORD_W` = 6, `ADDR_W` = 6.
  - State enum {`LEN`, `DATA`, `CHK`, `RUN`, `ERR`}.
- **Sub-module `prog_mem_array`**:
  - `DEPTH`×6 flop array.
  - Synchronous write port with `we`/`waddr`/`wdata` and a synchronous clear.
  - Combinational read port with out-of-range → 0.
- **Top** holds the FSM, counter, length register and checksum, plus the output mux.

## Test plan
- **Reset:** hold reset for 2 edges with random `io_in` → `io_out` = 0x00; after release, still 0x00 in `LEN`.
- **Good load:** feed 3, 1, 2, 3, chk = 3 → `io_out[6]` = 1 after the 5th edge. Then addresses 0/1/2 read 1/2/3, address 3 reads 0, address 40 reads 0.
- **Bad checksum:** feed 3, 1, 2, 3, 5 → `io_out` = 0x80 and it stays 0x80 across 10 further edges of arbitrary input.
- **Empty image:** feed 0, 0 → `RUN` after 2 edges; every address reads 0.
- **Overlong image** (DEPTH = 16): N = 20, words 1..20, chk = XOR(20, 1..20) → `RUN`. Address 15 reads 16; addresses 16..19 read 0.
- **Reset mid-DATA:** after 0x02, 0x07 (N = 2 and first data word 7 written to address 0), assert reset for 1 edge → then load 1, 9, chk = 8 → address 0 reads 9 and address 1 reads 0, so the prior word 7 is cleared.
